// File: rtl/counter_pkg.sv
// Shared types and key indices for the pausable up/down counter.
package counter_pkg;

  typedef enum logic [1:0] {
    RUN,
    PAUSE_HOLD,
    PAUSED,
    RESUME_HOLD
  } state_t;

  localparam int KEY_UP    = 0;
  localparam int KEY_DOWN  = 1;
  localparam int KEY_PAUSE = 2;
  localparam int KEY_CLR   = 3;

endpackage

// File: rtl/key_sync.sv
// Two-flop synchroniser for the raw push-buttons; resets to all ones (released).
module key_sync #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] async_i,
  output logic [N-1:0] sync_o
);

  logic [N-1:0] meta_q;
  logic [N-1:0] sync_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta_q <= '1;
      sync_q <= '1;
    end else begin
      meta_q <= async_i;
      sync_q <= meta_q;
    end
  end

  assign sync_o = sync_q;

endmodule

// File: rtl/pausable_updown_counter.sv
// Modulo-N up/down counter with prescaled tick, press/release pause FSM,
// separate direction register and level-sensitive clear.
module pausable_updown_counter
  import counter_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int MODULO   = 60,
  parameter int PRESCALE = 50_000_000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       key,
  output logic [WIDTH-1:0] count,
  output logic             up,
  output logic             pause,
  output logic             wrap
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0]    PRE_LAST = PW'(PRESCALE - 1);
  localparam logic [WIDTH-1:0] CNT_LAST = WIDTH'(MODULO - 1);

  logic [3:0]       ks;
  state_t           state_q, state_d;
  logic             up_q, up_d;
  logic [PW-1:0]    pre_q, pre_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic             wrap_q, wrap_d;
  logic             tick;
  logic             clr;

  key_sync #(.N(4)) u_key_sync (
    .clk     (clk),
    .reset   (reset),
    .async_i (key),
    .sync_o  (ks)
  );

  assign pause = (state_q == PAUSE_HOLD) || (state_q == PAUSED);
  assign clr   = ~ks[KEY_CLR];
  assign tick  = ~pause && (pre_q == PRE_LAST);

  // Pause toggles on press; the HOLD states wait for release so one press is one toggle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:         if (~ks[KEY_PAUSE]) state_d = PAUSE_HOLD;
      PAUSE_HOLD:  if (ks[KEY_PAUSE])  state_d = PAUSED;
      PAUSED:      if (~ks[KEY_PAUSE]) state_d = RESUME_HOLD;
      RESUME_HOLD: if (ks[KEY_PAUSE])  state_d = RUN;
      default:     state_d = RUN;
    endcase
  end

  always_comb begin
    up_d = up_q;
    if ((state_q == RUN) || (state_q == PAUSED)) begin
      if (~ks[KEY_UP] && ks[KEY_DOWN]) begin
        up_d = 1'b1;
      end else if (~ks[KEY_DOWN] && ks[KEY_UP]) begin
        up_d = 1'b0;
      end
    end
  end

  // Clear overrides any tick; the prescaler merely holds while paused.
  always_comb begin
    pre_d   = pre_q;
    count_d = count_q;
    wrap_d  = 1'b0;
    if (clr) begin
      pre_d   = '0;
      count_d = '0;
    end else if (tick) begin
      pre_d = '0;
      if (up_q) begin
        if (count_q == CNT_LAST) begin
          count_d = '0;
          wrap_d  = 1'b1;
        end else begin
          count_d = count_q + 1'b1;
        end
      end else begin
        if (count_q == '0) begin
          count_d = CNT_LAST;
          wrap_d  = 1'b1;
        end else begin
          count_d = count_q - 1'b1;
        end
      end
    end else if (~pause) begin
      pre_d = pre_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= RUN;
      up_q    <= 1'b1;
      pre_q   <= '0;
      count_q <= '0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      up_q    <= up_d;
      pre_q   <= pre_d;
      count_q <= count_d;
      wrap_q  <= wrap_d;
    end
  end

  assign count = count_q;
  assign up    = up_q;
  assign wrap  = wrap_q;

endmodule
